// File: rtl/mpaddsub_seq.sv
// mpaddsub_seq: multi-precision adder/subtractor, one CHUNK-bit slice per cycle.
//
// Operands are zero-padded to P = NCHUNK*CHUNK bits and fed LSB-first through
// a single CHUNK-bit adder; the carry ripples between slices in a flop.
//
// Ports
//   clk       in   clock, rising edge
//   resetn    in   synchronous active-low reset
//   start     in   request, accepted in IDLE or DONE
//   subtract  in   0: a+b, 1: a-b (sampled at accept)
//   in_a/in_b in   WIDTH-bit operands (sampled at accept)
//   busy      out  operation in progress
//   done      out  one-cycle pulse; result and flags valid from this cycle
//   result    out  WIDTH+1 bits: a+b zero-extended, or a-b sign-extended
//   borrow    out  subtract and a < b
//   zero      out  result == 0
//
// state  | meaning
// -------+---------------------------------------------
// IDLE   | waiting for start
// RUN    | processing one slice per cycle (NCHUNK cycles)
// DONE   | result/flags just updated; start re-accepts

module mpaddsub_seq #(
    parameter int WIDTH = 1027,
    parameter int CHUNK = 172
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             borrow,
    output logic             zero
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int P      = NCHUNK * CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last;

    logic [P-1:0]     a_sh;
    logic [P-1:0]     b_sh;
    logic [P-1:0]     sum_sh;
    logic [P-1:0]     sum_next;
    logic             carry;
    logic             carry_next;
    logic             op;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   s;
    logic [WIDTH:0]   res_next;

    // Slice adder: the only real logic on the critical path.
    always_comb begin
        b_slice    = op ? ~b_sh[CHUNK-1:0] : b_sh[CHUNK-1:0];
        s          = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
        carry_next = s[CHUNK];
        sum_next   = (sum_sh >> CHUNK) | (P'(s[CHUNK-1:0]) << (P - CHUNK));
    end

    // With padding, the inverted zero pad bits turn bit WIDTH of the sum into
    // the sign/carry bit directly. Without padding it must come from the
    // final carry-out (inverted for subtraction: carry-out 1 means no borrow).
    generate
        if (P > WIDTH) begin : g_padded
            logic unused_pad;
            assign res_next   = sum_next[WIDTH:0];
            assign unused_pad = ^sum_next;
        end else begin : g_exact
            assign res_next = {op ? ~carry_next : carry_next, sum_next[WIDTH-1:0]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        last       = (cnt == CW'(NCHUNK - 1));
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    accept     = 1'b1;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = S_RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            op     <= 1'b0;
            cnt    <= '0;
            result <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else if (accept) begin
            a_sh  <= P'(in_a);
            b_sh  <= P'(in_b);
            op    <= subtract;
            carry <= subtract;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> CHUNK;
            b_sh   <= b_sh >> CHUNK;
            sum_sh <= sum_next;
            carry  <= carry_next;
            cnt    <= cnt + 1'b1;
            if (last) begin
                result <= res_next;
                borrow <= op & res_next[WIDTH];
                zero   <= ~|res_next;
            end
        end
    end

endmodule

// File: tb/tb_mpaddsub_seq.sv
// Self-checking bench for mpaddsub_seq: directed timing/handshake/reset tests
// on the default configuration plus sweeps on three other parameter sets.
// Expected results are queued at accept and popped by per-instance monitors.

module tb_mpaddsub_seq;

    typedef logic [1027:0] w_t;
    typedef logic [1026:0] op_t;

    typedef struct packed {
        logic [1027:0] res;
        logic          brw;
        logic          zr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    // default instance (1027/172)
    logic        start_d, sub_d, busy_d, done_d, brw_d, zr_d;
    op_t         a_d, b_d;
    logic [1027:0] res_d;

    // 16-bit instances (16/5 and 16/16) share inputs
    logic        start_s, sub_s;
    logic [15:0] a_s, b_s;
    logic        busy_p5, done_p5, brw_p5, zr_p5;
    logic [16:0] res_p5;
    logic        busy_p16, done_p16, brw_p16, zr_p16;
    logic [16:0] res_p16;

    // bit-serial instance (1027/1)
    logic        start_c, sub_c, busy_c, done_c, brw_c, zr_c;
    op_t         a_c, b_c;
    logic [1027:0] res_c;

    exp_t q_d[$], q_p5[$], q_p16[$], q_c[$];
    exp_t e_d, e_p5, e_p16, e_c, e_h;

    int n_vec = 0;
    int n_err = 0;

    mpaddsub_seq u_dut (
        .clk(clk), .resetn(resetn), .start(start_d), .subtract(sub_d),
        .in_a(a_d), .in_b(b_d), .busy(busy_d), .done(done_d),
        .result(res_d), .borrow(brw_d), .zero(zr_d)
    );

    mpaddsub_seq #(.WIDTH(16), .CHUNK(5)) u_p5 (
        .clk(clk), .resetn(resetn), .start(start_s), .subtract(sub_s),
        .in_a(a_s), .in_b(b_s), .busy(busy_p5), .done(done_p5),
        .result(res_p5), .borrow(brw_p5), .zero(zr_p5)
    );

    mpaddsub_seq #(.WIDTH(16), .CHUNK(16)) u_p16 (
        .clk(clk), .resetn(resetn), .start(start_s), .subtract(sub_s),
        .in_a(a_s), .in_b(b_s), .busy(busy_p16), .done(done_p16),
        .result(res_p16), .borrow(brw_p16), .zero(zr_p16)
    );

    mpaddsub_seq #(.WIDTH(1027), .CHUNK(1)) u_c1 (
        .clk(clk), .resetn(resetn), .start(start_c), .subtract(sub_c),
        .in_a(a_c), .in_b(b_c), .busy(busy_c), .done(done_c),
        .result(res_c), .borrow(brw_c), .zero(zr_c)
    );

    task automatic check(input string tag, input w_t got, input w_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got(hi)=%h got(lo)=%h exp(hi)=%h exp(lo)=%h",
                     tag, got[1027:1000], got[127:0], exp[1027:1000], exp[127:0]);
        end
    endtask

    // Reference: plain wide arithmetic truncated to w+1 bits.
    function automatic exp_t model(input int w, input logic sub, input op_t a, input op_t b);
        w_t   r;
        w_t   mask;
        exp_t e;
        mask = '0;
        for (int i = 0; i <= w; i++) mask[i] = 1'b1;
        r = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        r = r & mask;
        e.res = r;
        e.brw = sub && (a < b);
        e.zr  = (r == '0);
        return e;
    endfunction

    function automatic op_t rnd_w();
        logic [1055:0] t;
        for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom();
        return t[1026:0];
    endfunction

    // monitors
    always @(negedge clk) if (done_d) begin
        check("d_pend", w_t'(q_d.size() != 0), w_t'(1));
        if (q_d.size() != 0) begin
            e_d = q_d.pop_front();
            check("d_res", res_d, e_d.res);
            check("d_brw", w_t'(brw_d), w_t'(e_d.brw));
            check("d_zero", w_t'(zr_d), w_t'(e_d.zr));
        end
    end

    always @(negedge clk) if (done_p5) begin
        check("p5_pend", w_t'(q_p5.size() != 0), w_t'(1));
        if (q_p5.size() != 0) begin
            e_p5 = q_p5.pop_front();
            check("p5_res", w_t'(res_p5), e_p5.res);
            check("p5_brw", w_t'(brw_p5), w_t'(e_p5.brw));
            check("p5_zero", w_t'(zr_p5), w_t'(e_p5.zr));
        end
    end

    always @(negedge clk) if (done_p16) begin
        check("p16_pend", w_t'(q_p16.size() != 0), w_t'(1));
        if (q_p16.size() != 0) begin
            e_p16 = q_p16.pop_front();
            check("p16_res", w_t'(res_p16), e_p16.res);
            check("p16_brw", w_t'(brw_p16), w_t'(e_p16.brw));
            check("p16_zero", w_t'(zr_p16), w_t'(e_p16.zr));
        end
    end

    always @(negedge clk) if (done_c) begin
        check("c1_pend", w_t'(q_c.size() != 0), w_t'(1));
        if (q_c.size() != 0) begin
            e_c = q_c.pop_front();
            check("c1_res", res_c, e_c.res);
            check("c1_brw", w_t'(brw_c), w_t'(e_c.brw));
            check("c1_zero", w_t'(zr_c), w_t'(e_c.zr));
        end
    end

    // Drive one request on the default instance; returns at the negedge of cycle 1.
    task automatic issue_d(input logic sub, input op_t a, input op_t b);
        a_d = a; b_d = b; sub_d = sub; start_d = 1'b1;
        q_d.push_back(model(1027, sub, a, b));
        @(posedge clk);
        @(negedge clk);
        start_d = 1'b0;
        a_d = rnd_w(); b_d = rnd_w(); sub_d = ~sub;
    endtask

    // Full op with latency and busy-length checks; returns at the done negedge.
    task automatic op_d(input logic sub, input op_t a, input op_t b);
        int busy_n;
        int done_at;
        issue_d(sub, a, b);
        busy_n = 0; done_at = 0;
        for (int n = 1; n <= 20 && done_at == 0; n++) begin
            if (busy_d) busy_n++;
            if (done_d) done_at = n;
            if (done_at == 0) @(negedge clk);
        end
        check("latency", w_t'(done_at), w_t'(7));
        check("busy_len", w_t'(busy_n), w_t'(6));
    endtask

    task automatic op_s(input logic sub, input logic [15:0] a, input logic [15:0] b);
        a_s = a; b_s = b; sub_s = sub; start_s = 1'b1;
        q_p5.push_back(model(16, sub, op_t'(a), op_t'(b)));
        q_p16.push_back(model(16, sub, op_t'(a), op_t'(b)));
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        a_s = 16'($urandom()); b_s = 16'($urandom());
        for (int t = 0; t < 20 && (q_p5.size() != 0 || q_p16.size() != 0); t++) @(negedge clk);
        check("s_drain", w_t'(q_p5.size() + q_p16.size()), w_t'(0));
    endtask

    task automatic op_c(input logic sub, input op_t a, input op_t b);
        a_c = a; b_c = b; sub_c = sub; start_c = 1'b1;
        q_c.push_back(model(1027, sub, a, b));
        @(posedge clk);
        @(negedge clk);
        start_c = 1'b0;
        a_c = rnd_w(); b_c = rnd_w();
        for (int t = 0; t < 1100 && q_c.size() != 0; t++) @(negedge clk);
        check("c1_drain", w_t'(q_c.size()), w_t'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t ones, pat, a1, b1;
        logic [1031:0] pat_w;
        int nd;

        resetn = 1'b0;
        start_d = 1'b0; sub_d = 1'b0; a_d = '0; b_d = '0;
        start_s = 1'b0; sub_s = 1'b0; a_s = '0; b_s = '0;
        start_c = 1'b0; sub_c = 1'b0; a_c = '0; b_c = '0;
        ones  = '1;
        pat_w = {129{8'h5A}};
        pat   = pat_w[1026:0];

        repeat (3) @(negedge clk);
        check("rst_busy", w_t'(busy_d), w_t'(0));
        check("rst_done", w_t'(done_d), w_t'(0));
        check("rst_res", res_d, w_t'(0));
        check("rst_zero", w_t'(zr_d), w_t'(0));
        check("rst_p5_busy", w_t'(busy_p5), w_t'(0));
        resetn = 1'b1;

        // directed arithmetic corners
        op_d(1'b0, ones, op_t'(1));
        check("carry_out", res_d, w_t'(1) << 1027);
        op_d(1'b1, op_t'(5), op_t'(7));
        check("neg_borrow", w_t'(brw_d), w_t'(1));
        op_d(1'b1, pat, pat);
        check("eq_zero", w_t'(zr_d), w_t'(1));

        // start pulses during RUN ignored; back-to-back accept in DONE
        a1 = rnd_w(); b1 = rnd_w();
        e_h = model(1027, 1'b0, a1, b1);
        issue_d(1'b0, a1, b1);
        nd = 0;
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            start_d = (k == 2 || k == 4);
            if (done_d && k < 7) nd++;
        end
        check("hs_ignored", w_t'(nd), w_t'(0));
        check("hs_done7", w_t'(done_d), w_t'(1));
        issue_d(1'b1, rnd_w(), rnd_w());
        for (int k = 1; k <= 6; k++) begin
            check("hold_res", res_d, e_h.res);
            check("b2b_busy", w_t'(busy_d), w_t'(1));
            @(negedge clk);
        end
        check("b2b_done", w_t'(done_d), w_t'(1));

        // reset in the middle of RUN
        issue_d(1'b0, rnd_w(), rnd_w());
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", w_t'(busy_d), w_t'(0));
        check("mid_rst_done", w_t'(done_d), w_t'(0));
        check("mid_rst_res", res_d, w_t'(0));
        check("mid_rst_brw", w_t'(brw_d), w_t'(0));
        check("mid_rst_zero", w_t'(zr_d), w_t'(0));
        q_d.delete();
        resetn = 1'b1;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_d) nd++;
        end
        check("rst_no_done", w_t'(nd), w_t'(0));
        op_d(1'b1, rnd_w(), rnd_w());

        for (int i = 0; i < 30; i++) op_d(1'($urandom()), rnd_w(), rnd_w());

        // 16-bit configurations: corners then random
        for (int s = 0; s < 2; s++) begin
            op_s(1'(s), 16'hFFFF, 16'hFFFF);
            op_s(1'(s), 16'h0000, 16'h0000);
            op_s(1'(s), 16'hFFFF, 16'h0000);
            op_s(1'(s), 16'h0000, 16'hFFFF);
        end
        for (int i = 0; i < 300; i++) op_s(1'($urandom()), 16'($urandom()), 16'($urandom()));

        // bit-serial configuration
        for (int s = 0; s < 2; s++) begin
            op_c(1'(s), ones, ones);
            op_c(1'(s), '0, '0);
            op_c(1'(s), ones, '0);
            op_c(1'(s), '0, ones);
        end
        for (int i = 0; i < 8; i++) op_c(1'($urandom()), rnd_w(), rnd_w());

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
